// File: rtl/conv_sched_pkg.sv
// Shared encodings and widths for the convolution window scheduler.
package conv_sched_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAITD = 3'd2,
        S_RUN   = 3'd3,
        S_STORE = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam int WIN_W              = 144;
    localparam int FP_W               = 16;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/conv_sched_if.sv
// Bundle of command, fetch, conv-unit and result signals around conv_sched.
interface conv_sched_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
);
    import conv_sched_pkg::*;

    // cmd and res are valid/ready: a transfer happens on a clock edge where both are high;
    // valid and its payload stay stable until that edge. rd_req, rd_valid and done are one-cycle pulses.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_channels;
    logic [CNT_W-1:0]  cmd_kernels;
    logic [ADDR_W-1:0] cmd_base;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [WIN_W-1:0]  rd_im;
    logic [WIN_W-1:0]  rd_iw;
    logic [WIN_W-1:0]  conv_im;
    logic [WIN_W-1:0]  conv_iw;
    logic              conv_ready;
    logic              conv_valid;
    logic [FP_W-1:0]   conv_om;
    logic              res_valid;
    logic              res_ready;
    logic [FP_W-1:0]   res_data;
    logic [CNT_W-1:0]  res_kernel;
    logic [CNT_W-1:0]  res_channel;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_channels, cmd_kernels, cmd_base,
        input  rd_valid, rd_im, rd_iw, conv_valid, conv_om, res_ready,
        output cmd_ready, rd_req, rd_addr, conv_im, conv_iw, conv_ready,
        output res_valid, res_data, res_kernel, res_channel, done, err
    );

    modport slave (
        output cmd_valid, cmd_channels, cmd_kernels, cmd_base,
        output rd_valid, rd_im, rd_iw, conv_valid, conv_om, res_ready,
        input  cmd_ready, rd_req, rd_addr, conv_im, conv_iw, conv_ready,
        input  res_valid, res_data, res_kernel, res_channel, done, err
    );
endinterface

// File: rtl/conv_sched_idx_cnt.sv
// sched_idx_cnt: nested channel (inner) / kernel (outer) window indices and last-window flag.
module sched_idx_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] channels_i,
    input  logic [CNT_W-1:0] kernels_i,
    output logic [CNT_W-1:0] chan_o,
    output logic [CNT_W-1:0] kern_o,
    output logic             last_o
);
    logic [CNT_W-1:0] chan_q, chan_d;
    logic [CNT_W-1:0] kern_q, kern_d;
    logic             chan_wrap;

    assign chan_wrap = (chan_q == channels_i - CNT_W'(1));

    always_comb begin
        chan_d = chan_q;
        kern_d = kern_q;
        if (clr_i) begin
            chan_d = '0;
            kern_d = '0;
        end else if (adv_i) begin
            if (chan_wrap) begin
                chan_d = '0;
                kern_d = kern_q + CNT_W'(1);
            end else begin
                chan_d = chan_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chan_q <= '0;
            kern_q <= '0;
        end else begin
            chan_q <= chan_d;
            kern_q <= kern_d;
        end
    end

    assign chan_o = chan_q;
    assign kern_o = kern_q;
    assign last_o = chan_wrap && (kern_q == kernels_i - CNT_W'(1));
endmodule

// File: rtl/conv_sched.sv
// conv_sched: fetches windows, runs them through the conv unit and hands out partial results.
// Optional watchdog on WAITD/RUN is enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int CNT_W          = 8,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    conv_sched_if.master bus,
    output state_t       dbg_state_o
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIN_W-1:0]  im_q, im_d, iw_q, iw_d;
    logic [FP_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  nch_q, nch_d, nkr_q, nkr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              idx_clr, idx_adv, idx_last;
    logic [CNT_W-1:0]  idx_chan, idx_kern;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    sched_idx_cnt #(.CNT_W(CNT_W)) u_idx (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (idx_clr),
        .adv_i      (idx_adv),
        .channels_i (nch_q),
        .kernels_i  (nkr_q),
        .chan_o     (idx_chan),
        .kern_o     (idx_kern),
        .last_o     (idx_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        im_d    = im_q;
        iw_d    = iw_q;
        res_d   = res_q;
        nch_d   = nch_q;
        nkr_d   = nkr_q;
        gap_d   = gap_q;
        last_d  = last_q;
        done_d  = 1'b0;
        idx_clr = 1'b0;
        idx_adv = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                nch_d   = bus.cmd_channels;
                nkr_d   = bus.cmd_kernels;
                addr_d  = bus.cmd_base;
                idx_clr = 1'b1;
                if (bus.cmd_channels == '0 || bus.cmd_kernels == '0) done_d = 1'b1;
                else                                                  state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WAITD;
            S_WAITD: if (bus.rd_valid) begin
                im_d    = bus.rd_im;
                iw_d    = bus.rd_iw;
                state_d = S_RUN;
            end
            S_RUN: if (bus.conv_valid) begin
                res_d   = bus.conv_om;
                state_d = S_STORE;
            end
            // Indices move only after the consumer has taken the result, so res_* stay stable in STORE.
            S_STORE: if (bus.res_ready) begin
                idx_adv = 1'b1;
                last_d  = idx_last;
                addr_d  = addr_q + ADDR_W'(1);
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CONV_SCHED_TIMEOUT_EN
        err_d = err_q;
        if ((state_q == S_WAITD || state_q == S_RUN) && state_d == state_q &&
            tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
        // Restart on every state entry so each wait gets its own full budget.
        if (state_d != state_q)                              tmo_d = '0;
        else if (state_q == S_WAITD || state_q == S_RUN)     tmo_d = tmo_q + TMO_W'(1);
        else                                                 tmo_d = tmo_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            im_q    <= '0;
            iw_q    <= '0;
            res_q   <= '0;
            nch_q   <= '0;
            nkr_q   <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            im_q    <= im_d;
            iw_q    <= iw_d;
            res_q   <= res_d;
            nch_q   <= nch_d;
            nkr_q   <= nkr_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

`ifdef CONV_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.rd_req      = (state_q == S_FETCH);
    assign bus.rd_addr     = addr_q;
    assign bus.conv_im     = im_q;
    assign bus.conv_iw     = iw_q;
    assign bus.conv_ready  = (state_q == S_RUN);
    assign bus.res_valid   = (state_q == S_STORE);
    assign bus.res_data    = res_q;
    assign bus.res_kernel  = idx_kern;
    assign bus.res_channel = idx_chan;
    assign bus.done        = done_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_conv_sched.sv
// Directed self-checking bench for conv_sched with fetch and conv-unit responders.
module tb_conv_sched;
    import conv_sched_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;

    conv_sched_if #(.ADDR_W(16), .CNT_W(8)) bus ();

    conv_sched #(.ADDR_W(16), .CNT_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: expected results {kernel, channel, data} and expected fetch addresses.
    logic [31:0] exp_q[$];
    logic [15:0] exp_addr_q[$];
    int          rd_seen = 0;
    int          done_seen = 0;
    int          conv_hi_seen = 0;
    int          cyc = 0;
    int          last_xfer = -1;
    logic        conv_en = 1'b1;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] pat_im(input logic [15:0] a);
        logic [143:0] v;
        for (int i = 0; i < 9; i++) v[i*16 +: 16] = a + 16'(i * 257);
        return v;
    endfunction

    function automatic logic [143:0] pat_iw(input logic [15:0] a);
        logic [143:0] v;
        for (int i = 0; i < 9; i++) v[i*16 +: 16] = (a ^ 16'h5A5A) + 16'(i * 3);
        return v;
    endfunction

    function automatic logic [15:0] om_of(input logic [143:0] im, input logic [143:0] iw);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s = s + im[i*16 +: 16] - iw[i*16 +: 16];
        return s;
    endfunction

    task automatic push_exp(input int ch, input int kr, input logic [15:0] base);
        logic [15:0] a;
        for (int k = 0; k < kr; k++) begin
            for (int c = 0; c < ch; c++) begin
                a = base + 16'(k * ch + c);
                exp_addr_q.push_back(a);
                exp_q.push_back({8'(k), 8'(c), om_of(pat_im(a), pat_iw(a))});
            end
        end
    endtask

    // Fetch memory: answers each rd_req two cycles later with address-derived data.
    initial begin
        logic [15:0] a;
        bus.rd_valid = 1'b0;
        bus.rd_im    = '0;
        bus.rd_iw    = '0;
        forever begin
            @(negedge clk);
            if (bus.rd_req) begin
                a = bus.rd_addr;
                repeat (2) @(negedge clk);
                bus.rd_im    = pat_im(a);
                bus.rd_iw    = pat_iw(a);
                bus.rd_valid = 1'b1;
                @(negedge clk);
                bus.rd_valid = 1'b0;
            end
        end
    end

    // Conv unit: raises conv_valid a few cycles into each run, drops it when conv_ready falls.
    initial begin
        int run_n;
        int run_lat;
        run_n = 0;
        run_lat = 1;
        bus.conv_valid = 1'b0;
        bus.conv_om    = '0;
        forever begin
            @(negedge clk);
            if (bus.conv_ready && conv_en) begin
                if (run_n == 0) run_lat = $urandom_range(1, 4);
                run_n++;
                if (run_n >= run_lat) begin
                    bus.conv_valid = 1'b1;
                    bus.conv_om    = om_of(bus.conv_im, bus.conv_iw);
                end
            end else begin
                run_n = 0;
                bus.conv_valid = 1'b0;
            end
        end
    end

    // Monitor: fetch addresses, result order, transfer-to-fetch and transfer-to-done spacing.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.conv_ready) conv_hi_seen++;
            if (bus.rd_req) begin
                rd_seen++;
                if (exp_addr_q.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
                else                        check("rd_addr", bus.rd_addr, exp_addr_q.pop_front());
                if (last_xfer >= 0) check("gap_len", cyc - last_xfer, 3);
                last_xfer = -1;
            end
            if (bus.done) begin
                done_seen++;
                if (last_xfer >= 0) check("done_gap", cyc - last_xfer, 3);
                last_xfer = -1;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_kcd", {bus.res_kernel, bus.res_channel, bus.res_data}, e);
                end
                last_xfer = cyc;
            end
        end
    end

    task automatic send_cmd(input logic [7:0] ch, input logic [7:0] kr, input logic [15:0] base);
        @(posedge clk);
        #1;
        bus.cmd_valid    = 1'b1;
        bus.cmd_channels = ch;
        bus.cmd_kernels  = kr;
        bus.cmd_base     = base;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, n < budget, 1'b1);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    task automatic wait_conv_ready(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.conv_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_run_seen"}, n < budget, 1'b1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        last_xfer = -1;
        @(negedge clk);
    endtask

    initial begin
        int rd0;
        int conv0;
        int exp_done;
        logic [15:0] hold_exp;
        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_channels = '0;
        bus.cmd_kernels  = '0;
        bus.cmd_base     = '0;
        bus.res_ready    = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_rd_req", bus.rd_req, 1'b0);
        check("rst_conv_ready", bus.conv_ready, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_rd_addr", bus.rd_addr, 16'h0000);
        check("rst_conv_im", bus.conv_im, 144'h0);
        check("rst_conv_iw", bus.conv_iw, 144'h0);
        check("rst_res_data", bus.res_data, 16'h0000);
        check("rst_res_kernel", bus.res_kernel, 8'h00);
        check("rst_res_channel", bus.res_channel, 8'h00);

        // 2 channels x 3 kernels from 0x0100, consumer always ready
        rd0 = rd_seen;
        push_exp(2, 3, 16'h0100);
        send_cmd(8'd2, 8'd3, 16'h0100);
        check("t1_cmd_ready_busy", bus.cmd_ready, 1'b0);
        wait_done(400, "t1");
        check("t1_rd_count", rd_seen - rd0, 6);
        check("t1_res_left", exp_q.size(), 0);
        check("t1_cmd_ready", bus.cmd_ready, 1'b1);

        // Zero-work commands: done the cycle after accept, nothing else
        rd0 = rd_seen;
        conv0 = conv_hi_seen;
        send_cmd(8'd0, 8'd4, 16'h0300);
        check("t2a_done", bus.done, 1'b1);
        check("t2a_rd_req", bus.rd_req, 1'b0);
        check("t2a_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        check("t2a_done_pulse", bus.done, 1'b0);
        send_cmd(8'd3, 8'd0, 16'h0300);
        check("t2b_done", bus.done, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_rd_count", rd_seen - rd0, 0);
        check("t2_conv_count", conv_hi_seen - conv0, 0);

        // Stalled consumer: 1 channel x 2 kernels from 0xFFFF exercises address wrap
        bus.res_ready = 1'b0;
        push_exp(1, 2, 16'hFFFF);
        hold_exp = om_of(pat_im(16'hFFFF), pat_iw(16'hFFFF));
        send_cmd(8'd1, 8'd2, 16'hFFFF);
        begin
            int n;
            n = 0;
            while (!bus.res_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t3_res_valid_seen", n < 100, 1'b1);
        end
        rd0 = rd_seen;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", bus.res_valid, 1'b1);
            check("t3_hold_data", bus.res_data, hold_exp);
        end
        check("t3_no_fetch", rd_seen - rd0, 0);
        check("t3_conv_low", bus.conv_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_done(200, "t3");
        check("t3_res_left", exp_q.size(), 0);

        // Reset while the conv unit is running
        conv_en = 1'b0;
        exp_addr_q.push_back(16'h0200);
        send_cmd(8'd1, 8'd1, 16'h0200);
        wait_conv_ready(50, "t4");
        check("t4_conv_im", bus.conv_im, pat_im(16'h0200));
        check("t4_conv_iw", bus.conv_iw, pat_iw(16'h0200));
        repeat (3) @(negedge clk);
        do_reset(2);
        check("t4_conv_ready", bus.conv_ready, 1'b0);
        check("t4_cmd_ready", bus.cmd_ready, 1'b1);
        check("t4_res_valid", bus.res_valid, 1'b0);

        // Conv unit never answers
        exp_addr_q.push_back(16'h0400);
        send_cmd(8'd1, 8'd1, 16'h0400);
        wait_conv_ready(50, "t5");
`ifdef CONV_SCHED_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("t5_still_run", bus.conv_ready, 1'b1);
        check("t5_no_done_yet", bus.done, 1'b0);
        check("t5_no_err_yet", bus.err, 1'b0);
        @(negedge clk);
        check("t5_tmo_done", bus.done, 1'b1);
        check("t5_tmo_err", bus.err, 1'b1);
        check("t5_tmo_conv_ready", bus.conv_ready, 1'b0);
        check("t5_tmo_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", bus.err, 1'b1);
        do_reset(2);
        check("t5_err_cleared", bus.err, 1'b0);
        exp_done = 6;
`else
        repeat (40) @(negedge clk);
        check("t5_hang_run", bus.conv_ready, 1'b1);
        check("t5_hang_state", dbg_state, S_RUN);
        check("t5_hang_err", bus.err, 1'b0);
        do_reset(2);
        check("t5_rst_conv_ready", bus.conv_ready, 1'b0);
        exp_done = 5;
`endif

        // Recovery: 3 channels x 1 kernel from 0x0010
        conv_en = 1'b1;
        push_exp(3, 1, 16'h0010);
        send_cmd(8'd3, 8'd1, 16'h0010);
        wait_done(300, "t6");
        check("t6_res_left", exp_q.size(), 0);
        check("t6_addr_left", exp_addr_q.size(), 0);
        check("done_total", done_seen, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
